// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA raster generator.
// Defaults describe 640x480 @ 60 Hz with a 25 MHz pixel clock.
package vga_pkg;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FP      = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BP      = 48;
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FP      = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BP      = 33;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Both syncs are asserted low.
    localparam logic SYNC_ACTIVE = 1'b0;

    typedef logic [9:0] coord_t;

    // Counter width for a modulus; a modulus of 1 still needs one storage bit.
    function automatic int unsigned cnt_width(input int unsigned modulus);
        int unsigned w;
        w = 1;
        while ((1 << w) < modulus) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with increment enable and synchronous active-high reset.
// wrap flags the increment that returns the count to zero.
module wrap_counter #(
    parameter int unsigned Mod   = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [Width-1:0] count,
    output logic             wrap
);

    localparam logic [Width-1:0] Last = Width'(Mod - 1);

    logic [Width-1:0] count_d;
    logic [Width-1:0] count_q;

    always_comb begin
        count_d = count_q;
        wrap    = inc && (count_q == Last);
        if (wrap) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: coordinates, syncs, visible-area flag, frame-end strobe
// and a slow animation index that advances every ANIM_DIV enabled frames.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter int unsigned ANIM_DIV  = 8,
    parameter int unsigned ANIM_W    = 2
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              anim_en,
    output coord_t            DrawX,
    output coord_t            DrawY,
    output logic              hs,
    output logic              vs,
    output logic              blank,
    output logic              sync,
    output logic              frame_end,
    output logic [ANIM_W-1:0] anim_frame
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned FDIV_W  = cnt_width(ANIM_DIV);

    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);
    localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);

    coord_t              hc;
    coord_t              vc;
    logic                hc_wrap;
    logic                vc_wrap;
    logic                fdiv_inc;
    logic                fdiv_wrap;
    logic [FDIV_W-1:0]   fdiv;
    logic [ANIM_W-1:0]   anim_frame_d;
    logic [ANIM_W-1:0]   anim_frame_q;

    wrap_counter #(
        .Mod   (H_TOTAL),
        .Width (10)
    ) u_hc (
        .clk   (vga_clk),
        .reset (reset),
        .inc   (1'b1),
        .count (hc),
        .wrap  (hc_wrap)
    );

    wrap_counter #(
        .Mod   (V_TOTAL),
        .Width (10)
    ) u_vc (
        .clk   (vga_clk),
        .reset (reset),
        .inc   (hc_wrap),
        .count (vc),
        .wrap  (vc_wrap)
    );

    wrap_counter #(
        .Mod   (ANIM_DIV),
        .Width (FDIV_W)
    ) u_fdiv (
        .clk   (vga_clk),
        .reset (reset),
        .inc   (fdiv_inc),
        .count (fdiv),
        .wrap  (fdiv_wrap)
    );

    // vc_wrap is exactly the last pixel of the last line; masked so the
    // strobe never appears while reset is held.
    assign frame_end = vc_wrap && !reset;
    assign fdiv_inc  = frame_end && anim_en;

    always_comb begin
        anim_frame_d = anim_frame_q;
        if (fdiv_wrap) begin
            anim_frame_d = anim_frame_q + ANIM_W'(1);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            anim_frame_q <= '0;
        end else begin
            anim_frame_q <= anim_frame_d;
        end
    end

    always_comb begin
        DrawX = hc;
        DrawY = vc;
        hs    = ((hc >= HS_START) && (hc < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vs    = ((vc >= VS_START) && (vc < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        blank = (hc < H_VIS_C) && (vc < V_VIS_C);
        sync  = 1'b0;
    end

    assign anim_frame = anim_frame_q;

    fdiv_in_range: assert property (@(posedge vga_clk) disable iff (reset)
        32'(fdiv) < ANIM_DIV);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a reduced-size generator and a default 640x480 generator
// are compared each cycle against a cycle-index model of the raster.
module tb_vga_timing_gen;

    localparam int SHV = 16, SHFP = 2, SHSY = 4, SHBP = 3;
    localparam int SVV = 10, SVFP = 2, SVSY = 2, SVBP = 3;
    localparam int SHT = SHV + SHFP + SHSY + SHBP;
    localparam int SVT = SVV + SVFP + SVSY + SVBP;
    localparam int SF  = SHT * SVT;
    localparam int VF  = 800 * 525;
    localparam int DIV = 8;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       sync;
        logic       fe;
        logic [1:0] anim;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       anim_en = 1'b0;

    logic [9:0] s_x, s_y, v_x, v_y;
    logic       s_hs, s_vs, s_blank, s_sync, s_fe;
    logic       v_hs, v_vs, v_blank, v_sync, v_fe;
    logic [1:0] s_anim, v_anim;

    obs_t act_s, act_v;
    assign act_s = {s_x, s_y, s_hs, s_vs, s_blank, s_sync, s_fe, s_anim};
    assign act_v = {v_x, v_y, v_hs, v_vs, v_blank, v_sync, v_fe, v_anim};

    obs_t q_s[$];
    obs_t q_v[$];
    int   checks = 0;
    int   passed = 0;
    int   n_s = 0, n_v = 0, cnt_s = 0, cnt_v = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE (SHV), .H_FP (SHFP), .H_SYNC (SHSY), .H_BP (SHBP),
        .V_VISIBLE (SVV), .V_FP (SVFP), .V_SYNC (SVSY), .V_BP (SVBP),
        .ANIM_DIV  (DIV), .ANIM_W (2)
    ) u_dut_small (
        .vga_clk    (clk),
        .reset      (reset),
        .anim_en    (anim_en),
        .DrawX      (s_x),
        .DrawY      (s_y),
        .hs         (s_hs),
        .vs         (s_vs),
        .blank      (s_blank),
        .sync       (s_sync),
        .frame_end  (s_fe),
        .anim_frame (s_anim)
    );

    vga_timing_gen u_dut_vga (
        .vga_clk    (clk),
        .reset      (reset),
        .anim_en    (anim_en),
        .DrawX      (v_x),
        .DrawY      (v_y),
        .hs         (v_hs),
        .vs         (v_vs),
        .blank      (v_blank),
        .sync       (v_sync),
        .frame_end  (v_fe),
        .anim_frame (v_anim)
    );

    // Expected outputs from the cycle index within the frame.
    function automatic obs_t model(input int n, input int cnt, input bit big);
        int   hv, hfp, hsy, ht, vv, vfp, vsy, vt, x, y;
        obs_t o;
        if (big) begin
            hv = 640; hfp = 16; hsy = 96; ht = 800;
            vv = 480; vfp = 10; vsy = 2;  vt = 525;
        end else begin
            hv = SHV; hfp = SHFP; hsy = SHSY; ht = SHT;
            vv = SVV; vfp = SVFP; vsy = SVSY; vt = SVT;
        end
        x       = n % ht;
        y       = n / ht;
        o.x     = 10'(x);
        o.y     = 10'(y);
        o.hs    = !((x >= hv + hfp) && (x < hv + hfp + hsy));
        o.vs    = !((y >= vv + vfp) && (y < vv + vfp + vsy));
        o.blank = (x < hv) && (y < vv);
        o.sync  = 1'b0;
        o.fe    = (n == ht * vt - 1);
        o.anim  = 2'((cnt / DIV) % 4);
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s t=%0t act x=%0d y=%0d hs=%b vs=%b blank=%b sync=%b fe=%b anim=%0d exp x=%0d y=%0d hs=%b vs=%b blank=%b sync=%b fe=%b anim=%0d",
                     name, $time, act.x, act.y, act.hs, act.vs, act.blank, act.sync, act.fe,
                     act.anim, exp.x, exp.y, exp.hs, exp.vs, exp.blank, exp.sync, exp.fe,
                     exp.anim);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s t=%0t act=%0d exp=%0d", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e);
        @(negedge clk);
        reset   = r;
        anim_en = e;
    endtask

    // Advance the model with the inputs consumed at this edge; queue expectations.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            n_s = 0; n_v = 0; cnt_s = 0; cnt_v = 0;
        end else begin
            if (n_s == SF - 1 && anim_en) cnt_s++;
            if (n_v == VF - 1 && anim_en) cnt_v++;
            n_s = (n_s + 1) % SF;
            n_v = (n_v + 1) % VF;
        end
        q_s.push_back(model(n_s, cnt_s, 1'b0));
        q_v.push_back(model(n_v, cnt_v, 1'b1));
    endtask

    task automatic step(input logic r, input logic e);
        drive(r, e);
        tick();
    endtask

    // Monitor: DUT outputs are valid every cycle, sampled just after the edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                check_obs("small", act_s, e);
            end
            if (q_v.size() > 0) begin
                e = q_v.pop_front();
                check_obs("vga", act_v, e);
            end
        end
    end

    initial begin
        repeat (3) step(1'b1, 1'b1);
        #1;
        check_val("reset_x", int'(s_x), 0);
        check_val("reset_hs", int'(v_hs), 1);
        check_val("reset_blank", int'(v_blank), 1);

        // Continuous enable for 32 frames: index steps at frames 8, 16, 24, 32.
        repeat (32 * SF) step(1'b0, 1'b1);

        // Enable dropped for frame_ends 3..6: first step moves to the 12th.
        step(1'b1, 1'b1);
        for (int f = 1; f <= 13; f++) begin
            repeat (SF) step(1'b0, !(f >= 3 && f <= 6));
            #1;
            if (f == 11) check_val("anim_hold_f11", int'(s_anim), 0);
            if (f == 12) check_val("anim_step_f12", int'(s_anim), 1);
        end

        // Mid-frame reset at (12,9).
        repeat (9 * SHT + 12) step(1'b0, 1'b1);
        #1;
        check_val("mid_pos_x", int'(s_x), 12);
        step(1'b1, 1'b1);
        #1;
        check_val("mid_rst_anim", int'(s_anim), 0);
        check_val("mid_rst_y", int'(s_y), 0);

        // Reset coinciding with the frame_end that would wrap the divider.
        repeat (7 * SF) step(1'b0, 1'b1);
        repeat (SF - 1) step(1'b0, 1'b1);
        #1;
        check_val("fe_before_rst", int'(s_fe), 1);
        drive(1'b1, 1'b1);
        #1;
        check_val("fe_in_reset", int'(s_fe), 0);
        tick();
        #1;
        check_val("rst_fe_anim", int'(s_anim), 0);
        repeat (SF) step(1'b0, 1'b1);
        #1;
        check_val("no_step_after", int'(s_anim), 0);

        // Random enable with occasional reset pulses.
        repeat (10 * SF) step(($urandom_range(0, 999) == 0), 1'($urandom_range(0, 1)));

        @(posedge clk);
        #2;
        check_val("queue_drained", q_s.size() + q_v.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
